// File: rtl/apb_fifo_completer_if.sv
// APB completer bus plus the upstream (RX) and downstream (TX) valid/ready streams.
// The slave modport is the completer's view; master is the requester/stream-partner view.
interface apb_fifo_completer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  logic              up_valid;
  logic              up_ready;
  logic [DATA_W-1:0] up_data;

  logic              down_valid;
  logic              down_ready;
  logic [DATA_W-1:0] down_data;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr,
    input  up_valid, up_data,
    output up_ready,
    output down_valid, down_data,
    input  down_ready
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr,
    output up_valid, up_data,
    input  up_ready,
    input  down_valid, down_data,
    output down_ready
  );
endinterface

// File: rtl/apb_fifo_completer.sv
// APB completer bridging a DATA register onto TX/RX flip-flop FIFOs, with wait states,
// a wait-state timeout and error responses for unmapped or read-only targets.
module apb_fifo_completer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 10,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_fifo_completer_if.slave  bus
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] ADDR_DATA = '0;
  localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(4);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic [DATA_W-1:0]   tx_mem_q [DEPTH];
  logic [PTR_W-1:0]    tx_wr_q, tx_wr_d;
  logic [PTR_W-1:0]    tx_rd_q, tx_rd_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;

  logic [DATA_W-1:0]   rx_mem_q [DEPTH];
  logic [PTR_W-1:0]    rx_wr_q, rx_wr_d;
  logic [PTR_W-1:0]    rx_rd_q, rx_rd_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;

  logic                tx_full, tx_empty, rx_full, rx_empty;
  logic                access, is_data, is_stat, timed_out;
  logic                pready, pslverr;
  logic [DATA_W-1:0]   prdata;
  logic [DATA_W-1:0]   status_word;
  logic                apb_push, apb_pop, down_pop, up_push;

  // Flags come from registered counts only, so a pop never frees a slot in the same cycle.
  assign tx_full   = (tx_cnt_q == CNT_W'(DEPTH));
  assign tx_empty  = (tx_cnt_q == '0);
  assign rx_full   = (rx_cnt_q == CNT_W'(DEPTH));
  assign rx_empty  = (rx_cnt_q == '0);

  assign access    = bus.psel & bus.penable & ~rst;
  assign is_data   = (bus.paddr == ADDR_DATA);
  assign is_stat   = (bus.paddr == ADDR_STAT);
  assign timed_out = (wait_q == WAIT_W'(TIMEOUT));

  assign status_word = DATA_W'({tx_cnt_q, rx_cnt_q});

  always_comb begin
    pready   = 1'b0;
    pslverr  = 1'b0;
    prdata   = '0;
    apb_push = 1'b0;
    apb_pop  = 1'b0;
    if (access) begin
      if (!(is_data || is_stat) || (is_stat && bus.pwrite)) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end else if (timed_out) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end else if (is_data && bus.pwrite) begin
        if (!tx_full) begin
          pready   = 1'b1;
          apb_push = 1'b1;
        end
      end else if (is_data) begin
        if (!rx_empty) begin
          pready  = 1'b1;
          apb_pop = 1'b1;
          prdata  = rx_mem_q[rx_rd_q];
        end
      end else begin
        pready = 1'b1;
        prdata = status_word;
      end
    end
  end

  assign bus.pready     = pready;
  assign bus.pslverr    = pslverr;
  assign bus.prdata     = prdata;

  assign down_pop       = ~tx_empty & bus.down_ready;
  assign up_push        = ~rx_full & bus.up_valid;

  assign bus.down_valid = ~tx_empty;
  assign bus.down_data  = tx_empty ? '0 : tx_mem_q[tx_rd_q];
  assign bus.up_ready   = ~rx_full;

  // wait_d counts wait states of the current transfer; the first one is taken from IDLE.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      IDLE: begin
        if (access && !pready) begin
          state_d = ACCESS;
          wait_d  = WAIT_W'(1);
        end
      end
      ACCESS: begin
        if (!access || pready) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_wr_d  = apb_push ? ptr_inc(tx_wr_q) : tx_wr_q;
    tx_rd_d  = down_pop ? ptr_inc(tx_rd_q) : tx_rd_q;
    tx_cnt_d = tx_cnt_q + CNT_W'(apb_push) - CNT_W'(down_pop);

    rx_wr_d  = up_push ? ptr_inc(rx_wr_q) : rx_wr_q;
    rx_rd_d  = apb_pop ? ptr_inc(rx_rd_q) : rx_rd_q;
    rx_cnt_d = rx_cnt_q + CNT_W'(up_push) - CNT_W'(apb_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // Storage is never cleared; emptiness is tracked by the counts and outputs are gated by it.
  always_ff @(posedge clk) begin
    if (apb_push) tx_mem_q[tx_wr_q] <= bus.pwdata;
    if (up_push && !rst) rx_mem_q[rx_wr_q] <= bus.up_data;
  end

endmodule

// File: tb/tb_apb_fifo_completer.sv
// Bench for apb_fifo_completer: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_apb_fifo_completer;
  localparam int DW = 8, DEPTH = 10, AW = 4, TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_fifo_completer_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  apb_fifo_completer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  int            wcnt = 0;

  logic          e_pready, e_pslverr;
  logic [DW-1:0] e_prdata;
  logic          a_pready, a_pslverr, a_dv, a_ur;
  logic [DW-1:0] a_prdata, a_dd;

  typedef struct {
    logic          psel, pen, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          upv;
    logic [DW-1:0] upd;
    logic          dr;
    logic          x_pready, x_err;
    logic [DW-1:0] x_rd;
    logic          x_dv;
    logic [DW-1:0] x_dd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic psel, input logic pen, input logic wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input logic upv, input logic [DW-1:0] upd,
                     input logic dr, input logic xp, input logic xe, input logic [DW-1:0] xr,
                     input logic xdv, input logic [DW-1:0] xdd);
    vec_t v;
    v.psel = psel; v.pen = pen; v.wr = wr; v.addr = addr; v.wd = wd;
    v.upv = upv; v.upd = upd; v.dr = dr;
    v.x_pready = xp; v.x_err = xe; v.x_rd = xr; v.x_dv = xdv; v.x_dd = xdd;
    tbl.push_back(v);
  endtask

  // Reference: completion decided from the queue occupancies and the wait-state count.
  task automatic model_eval();
    logic acc;
    acc = bus.psel && bus.penable && !rst;
    e_pready = 1'b0; e_pslverr = 1'b0; e_prdata = '0;
    if (acc) begin
      if (!(bus.paddr == 0 || bus.paddr == 4) || (bus.paddr == 4 && bus.pwrite)) begin
        e_pready = 1'b1; e_pslverr = 1'b1;
      end else if (wcnt == TMO) begin
        e_pready = 1'b1; e_pslverr = 1'b1;
      end else if (bus.paddr == 0 && bus.pwrite) begin
        e_pready = (txq.size() < DEPTH);
      end else if (bus.paddr == 0) begin
        if (rxq.size() > 0) begin e_pready = 1'b1; e_prdata = rxq[0]; end
      end else begin
        e_pready = 1'b1;
        e_prdata = DW'(txq.size() * 16 + rxq.size());
      end
    end
  endtask

  task automatic cyc();
    logic acc, tx_pop, rx_push, ok;
    @(negedge clk);
    model_eval();
    a_pready = bus.pready; a_pslverr = bus.pslverr; a_prdata = bus.prdata;
    a_dv = bus.down_valid; a_dd = bus.down_data; a_ur = bus.up_ready;
    check("pready", a_pready, e_pready);
    check("pslverr", a_pslverr, e_pslverr);
    check("prdata", a_prdata, e_prdata);
    check("down_valid", a_dv, txq.size() > 0);
    check("down_data", a_dd, (txq.size() > 0) ? txq[0] : 8'h00);
    check("up_ready", a_ur, rxq.size() < DEPTH);
    acc = bus.psel && bus.penable && !rst;
    ok  = acc && e_pready && !e_pslverr;
    if (rst) begin
      txq.delete(); rxq.delete(); wcnt = 0;
    end else begin
      tx_pop  = bus.down_ready && (txq.size() > 0);
      rx_push = bus.up_valid && (rxq.size() < DEPTH);
      if (tx_pop) void'(txq.pop_front());
      if (ok && bus.pwrite) txq.push_back(bus.pwdata);
      if (ok && !bus.pwrite && bus.paddr == 0) void'(rxq.pop_front());
      if (rx_push) rxq.push_back(bus.up_data);
      wcnt = (acc && !e_pready) ? wcnt + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apb(input logic psel, input logic pen, input logic wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd);
    bus.psel = psel; bus.penable = pen; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
  endtask

  initial begin
    int waits;
    bit done, busy;
    int r;

    apb(0, 0, 0, '0, '0);
    bus.up_valid = 0; bus.up_data = '0; bus.down_ready = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc();
    check("rst_up_ready", a_ur, 1);
    check("rst_down_valid", a_dv, 0);
    check("rst_pready", a_pready, 0);
    rst = 1'b0;

    // psel pen wr addr wd | upv upd dr | pready err prdata down_valid down_data
    add(1, 0, 1, 4'h0, 8'hA5, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 1, 4'h0, 8'hA5, 0, 8'h00, 1, 1, 0, 8'h00, 0, 8'h00);
    add(0, 0, 0, 4'h0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 1, 8'hA5);
    add(0, 0, 0, 4'h0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 0, 4'h0, 8'h00, 1, 8'h11, 0, 0, 0, 8'h00, 0, 8'h00);
    add(0, 0, 0, 4'h0, 8'h00, 1, 8'h22, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 0, 0, 4'h4, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 0, 4'h4, 8'h00, 0, 8'h00, 0, 1, 0, 8'h02, 0, 8'h00);
    add(1, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 0, 4'h0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h11, 0, 8'h00);
    add(1, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 0, 4'h0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h22, 0, 8'h00);
    add(1, 0, 1, 4'h4, 8'hFF, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 1, 4'h4, 8'hFF, 0, 8'h00, 0, 1, 1, 8'h00, 0, 8'h00);
    add(1, 0, 0, 4'h8, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 0, 4'h8, 8'h00, 0, 8'h00, 0, 1, 1, 8'h00, 0, 8'h00);
    add(1, 0, 0, 4'h4, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    add(1, 1, 0, 4'h4, 8'h00, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00);

    foreach (tbl[i]) begin
      apb(tbl[i].psel, tbl[i].pen, tbl[i].wr, tbl[i].addr, tbl[i].wd);
      bus.up_valid = tbl[i].upv; bus.up_data = tbl[i].upd; bus.down_ready = tbl[i].dr;
      cyc();
      check($sformatf("tbl%0d_pready", i), a_pready, tbl[i].x_pready);
      check($sformatf("tbl%0d_pslverr", i), a_pslverr, tbl[i].x_err);
      check($sformatf("tbl%0d_prdata", i), a_prdata, tbl[i].x_rd);
      check($sformatf("tbl%0d_down_valid", i), a_dv, tbl[i].x_dv);
      check($sformatf("tbl%0d_down_data", i), a_dd, tbl[i].x_dd);
    end
    apb(0, 0, 0, '0, '0);
    bus.up_valid = 0; bus.down_ready = 0;

    // TX full: eleventh write waits until a downstream pop frees a slot.
    for (int i = 0; i < DEPTH; i++) begin
      apb(1, 0, 1, 4'h0, 8'h40 + 8'(i)); cyc();
      apb(1, 1, 1, 4'h0, 8'h40 + 8'(i)); cyc();
      check("fill_zero_wait", a_pready, 1);
    end
    apb(1, 0, 1, 4'h0, 8'h3C); cyc();
    bus.penable = 1;
    for (int w = 1; w <= 3; w++) begin
      bus.down_ready = (w == 3);
      cyc();
      check("full_wait", a_pready, 0);
    end
    bus.down_ready = 0;
    cyc();
    check("full_release_pready", a_pready, 1);
    check("full_release_err", a_pslverr, 0);
    apb(0, 0, 0, '0, '0);
    bus.down_ready = 1;
    for (int j = 0; j < DEPTH; j++) begin
      cyc();
      check("drain_valid", a_dv, 1);
      check("drain_data", a_dd, (j < DEPTH - 1) ? 8'h41 + 8'(j) : 8'h3C);
    end
    cyc();
    check("drain_empty", a_dv, 0);
    bus.down_ready = 0;

    // Read of empty RX times out after exactly TMO wait states.
    apb(1, 0, 0, 4'h0, '0); cyc();
    bus.penable = 1;
    waits = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc();
      if (a_pready || e_pready) done = 1;
      else waits++;
    end
    check("timeout_done", done, 1);
    check("timeout_waits", waits, TMO);
    check("timeout_pready", a_pready, 1);
    check("timeout_err", a_pslverr, 1);
    check("timeout_prdata", a_prdata, 0);
    apb(1, 0, 0, 4'h4, '0); cyc();
    bus.penable = 1; cyc();
    check("timeout_status", a_prdata, 8'h00);
    apb(0, 0, 0, '0, '0);

    // Reset during a DATA read with three RX words held.
    bus.up_valid = 1;
    for (int j = 0; j < 3; j++) begin bus.up_data = 8'h71 + 8'(j); cyc(); end
    bus.up_valid = 0;
    apb(1, 0, 0, 4'h0, '0); cyc();
    bus.penable = 1; rst = 1; cyc();
    check("rst_mid_pready", a_pready, 0);
    rst = 0; apb(0, 0, 0, '0, '0); cyc();
    check("rst_mid_up_ready", a_ur, 1);
    apb(1, 0, 0, 4'h4, '0); cyc();
    bus.penable = 1; cyc();
    check("rst_mid_status", a_prdata, 8'h00);
    apb(0, 0, 0, '0, '0);

    busy = 0;
    for (int n = 0; n < 800; n++) begin
      if (!busy) begin
        if ($urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 7);
          bus.paddr   = (r < 5) ? 4'h0 : (r < 7) ? 4'h4 : AW'($urandom_range(0, 15));
          bus.pwrite  = 1'($urandom_range(0, 1));
          bus.pwdata  = DW'($urandom);
          bus.psel    = 1; bus.penable = 0; busy = 1;
        end else begin
          bus.psel = 0; bus.penable = 0;
        end
      end else begin
        bus.penable = 1;
      end
      bus.up_valid   = 1'($urandom_range(0, 1));
      bus.up_data    = DW'($urandom);
      bus.down_ready = ($urandom_range(0, 2) != 0);
      cyc();
      if (busy && bus.penable && e_pready) begin
        busy = 0; bus.psel = 0; bus.penable = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/apb_fifo_completer.md
# apb_fifo_completer

APB completer that terminates transfers from an APB requester and bridges them onto valid/ready streams through two internal flip-flop FIFOs. A write to the DATA register enqueues a word into the TX FIFO, which drains on the downstream port. A read from DATA dequeues a word from the RX FIFO, which fills from the upstream port. The completer inserts wait states while the FIFO it needs is full or empty, and ends a transfer with an error on timeout or on a bad address.

## Interface
- width, 8: data width of APB data and of both streams
- depth, 10: entries per FIFO (TX and RX each)
- addr_width, 4: PADDR width
- timeout, 15: maximum number of wait states before an error response; must be ≥ 1
- Constraint: width ≥ 2·$clog2(depth+1)

- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  addr_width  byte address
- pwdata  in  width  write data
- prdata  out  width  read data, valid only when pready=1 on a read
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid only when pready=1
- up_valid  in  1  RX stream valid
- up_ready  out  1  RX stream ready = RX FIFO not full
- up_data  in  width  RX stream data
- down_valid  out  1  TX stream valid = TX FIFO not empty
- down_ready  in  1  TX stream ready
- down_data  out  width  TX FIFO head

## Operation
- Register map:
  - 0x0 DATA: write pushes to TX; read pops from RX.
  - 0x4 STATUS: read-only; prdata = {zero pad, tx_count, rx_count}, each count $clog2(depth+1) bits, rx_count in the LSBs.
  - Any other address is unmapped.
- Access phase: psel=1 and penable=1. The setup phase (psel=1, penable=0) produces no response.
- FSM:
  - IDLE → ACCESS when the access phase starts and pready=0 that cycle.
  - ACCESS → IDLE on the cycle pready=1.
  - Zero-wait transfers never leave IDLE.
  - wait_cnt clears in IDLE and increments each ACCESS cycle with pready=0.
- pready and pslverr are combinational from registered state, FIFO flags and the APB inputs; they are 0 outside the access phase.
- Completion rules, in priority order:
  1. Unmapped address, or write to STATUS → pready=1, pslverr=1 immediately. No FIFO effect.
  2. wait_cnt == timeout → pready=1, pslverr=1. No push or pop; prdata=0.
  3. DATA write with TX not full → pready=1, pslverr=0. Push pwdata on this edge.
  4. DATA read with RX not empty → pready=1, pslverr=0. prdata = RX head; pop on this edge.
  5. STATUS read → pready=1, pslverr=0, zero wait.
  6. Otherwise pready=0 (wait state).
- prdata=0 whenever it is not a completing, non-error read.
- FIFO full and empty flags are registered state. There is no same-cycle bypass:
  - A downstream pop from a full TX lets a pending write complete on the next cycle, not the same one.
  - An upstream push into an empty RX satisfies a pending read on the next cycle.
- Simultaneous APB push and down pop on the same FIFO: both happen and the count is unchanged. The same holds for an up push and an APB pop on RX.
- Pointers wrap from depth-1 to 0. Counts saturate structurally because push is gated by full and pop is gated by empty.

## Timing
- Reset values:
  - pready=0, pslverr=0, prdata=0
  - up_ready=1, down_valid=0, down_data=0
  - both FIFOs empty, counts 0, FSM IDLE, wait_cnt 0
- Reset mid-transfer: the transfer is abandoned with no pready, FIFO contents are discarded, and the FSM returns to IDLE.
- Best-case APB latency is 2 cycles (setup plus access), with zero wait states.
- Blocked transfer: pready rises on the first access cycle where the condition holds, at most timeout wait states later.
- A TX word pushed at edge N is visible on down_valid/down_data after edge N.
- An RX word accepted at edge N is readable by a transfer whose access cycle is after edge N.
- If the requester changes paddr or pwrite while pready=0 in the access phase, that is a protocol violation and the behaviour is unspecified.

## Test plan
- Reset, then write DATA=0xA5 with down_ready=1 → zero wait states, pslverr=0; down_valid=1 and down_data=0xA5 the next cycle, then the word drains.
- Fill TX with 10 writes while down_ready=0, then issue an 11th write 0x3C → pready low. Raise down_ready for one cycle at wait 3 → pready=1 on the following cycle; 0x3C ends up at the tail.
- Read DATA with RX empty and no upstream traffic, timeout=15 → exactly 15 wait states, then pready=1, pslverr=1, prdata=0; FIFO unchanged.
- Push 0x11, 0x22 upstream, then read STATUS → prdata=0x02. Read DATA twice → 0x11 then 0x22, both zero-wait.
- Write to 0x4 and read 0x8 → each pready=1, pslverr=1 in the first access cycle; counts unchanged.
- Assert rst during a DATA-read wait state with RX holding 3 words → pready stays 0, rx_count=0, up_ready=1 after reset.
